// File: rtl/vga_timing_pkg.sv
// Shared definitions for the raster timing generator: FSM encoding and
// standard display mode constant sets for instantiation.
package vga_timing_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } vga_state_e;

  typedef struct packed {
    logic [15:0] hActive;
    logic [15:0] hFp;
    logic [15:0] hSync;
    logic [15:0] hBp;
    logic [15:0] vActive;
    logic [15:0] vFp;
    logic [15:0] vSync;
    logic [15:0] vBp;
    logic        hsPol;
    logic        vsPol;
  } vga_mode_t;

  // 640x480@60, 25.175 MHz pixel rate, both syncs active-low
  localparam vga_mode_t VGA_640X480 = '{
    hActive: 16'd640, hFp: 16'd16, hSync: 16'd96,  hBp: 16'd48,
    vActive: 16'd480, vFp: 16'd10, vSync: 16'd2,   vBp: 16'd33,
    hsPol: 1'b0, vsPol: 1'b0
  };

  // 800x600@60, 40 MHz pixel rate, both syncs active-high
  localparam vga_mode_t VGA_800X600 = '{
    hActive: 16'd800, hFp: 16'd40, hSync: 16'd128, hBp: 16'd88,
    vActive: 16'd600, vFp: 16'd1,  vSync: 16'd4,   vBp: 16'd23,
    hsPol: 1'b1, vsPol: 1'b1
  };

endpackage

// File: rtl/vga_sig_delay.sv
// WIDTH x DEPTH shift register that advances only on en_i. Asynchronous
// active-low clear loads RESET_VAL into every stage. DEPTH = 0 is a wire.
module vga_sig_delay #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (DEPTH == 0) begin : g_pass
    logic unusedCtrl;
    assign unusedCtrl = ^{clk, rst_n, en_i};
    assign q_o = d_i;
  end else begin : g_shift
    logic [WIDTH-1:0] stage_q [DEPTH];

    // Shift one stage per enabled tick; reset clears all stages to the idle word
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) stage_q[i] <= RESET_VAL;
      end else if (en_i) begin
        stage_q[0] <= d_i;
        for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign q_o = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator running from the system clock with a
// pixel-rate enable. Stops only on frame boundaries; all raster outputs are
// registered once and then delayed by PIPE_DLY pixel ticks.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int PIPE_DLY = 0,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW      = $clog2(H_TOTAL),
  localparam int VW      = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pix_en,
  input  logic          run,
  output logic          busy,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [HW-1:0] x,
  output logic [VW-1:0] y,
  output logic          line_start,
  output logic          frame_start
);

  localparam int W = 5 + HW + VW;

  localparam logic [HW-1:0] H_LAST       = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST       = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_END    = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_ACT_END    = VW'(V_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYNC_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_SYNC_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

  // Word driven while idle and loaded on reset: syncs deasserted, all else 0
  localparam logic [W-1:0] IDLE_WORD = {~HS_POL, ~VS_POL, 1'b0, {HW{1'b0}}, {VW{1'b0}}, 2'b00};

  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
      PIPE_DLY < 0 || PIPE_DLY > 15) begin : g_param_check
    $error("vga_timing_gen: porch/sync widths must be >= 1 and PIPE_DLY in 0..15");
  end

  vga_state_e    state_q;
  logic          busy_q;
  logic [HW-1:0] hCnt_q, hCnt_d;
  logic [VW-1:0] vCnt_q, vCnt_d;
  logic [W-1:0]  stage0_q, stage0_d;
  logic [W-1:0]  delayed;
  logic          active, advance, atWrap;

  // IDLE with run sampled high already counts as an active pixel so (0,0) goes out on that tick
  assign active  = (state_q != IDLE) || run;
  assign advance = pix_en && active;
  assign atWrap  = (hCnt_q == H_LAST) && (vCnt_q == V_LAST);

  // Run/stop FSM; leaving for IDLE is only allowed on the frame wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
    end else if (pix_en) begin
      case (state_q)
        IDLE: begin
          if (run) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
          end
        end
        RUN, STOP: begin
          if (atWrap && !run) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (run) begin
            state_q <= RUN;
          end else begin
            state_q <= STOP;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Next raster position: column wraps at line end, row steps on column wrap
  always_comb begin
    hCnt_d = hCnt_q;
    vCnt_d = vCnt_q;
    if (advance) begin
      if (hCnt_q == H_LAST) begin
        hCnt_d = '0;
        vCnt_d = (vCnt_q == V_LAST) ? '0 : vCnt_q + 1'b1;
      end else begin
        hCnt_d = hCnt_q + 1'b1;
      end
    end
  end

  // Raster position registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hCnt_q <= '0;
      vCnt_q <= '0;
    end else begin
      hCnt_q <= hCnt_d;
      vCnt_q <= vCnt_d;
    end
  end

  // Decode the current position into sync/enable/coordinate/strobe values
  always_comb begin
    logic hSyncOn, vSyncOn, deNow;
    hSyncOn  = (hCnt_q >= H_SYNC_START) && (hCnt_q < H_SYNC_END);
    vSyncOn  = (vCnt_q >= V_SYNC_START) && (vCnt_q < V_SYNC_END);
    deNow    = (hCnt_q < H_ACT_END) && (vCnt_q < V_ACT_END);
    stage0_d = IDLE_WORD;
    if (active) begin
      stage0_d = {hSyncOn ? HS_POL : ~HS_POL,
                  vSyncOn ? VS_POL : ~VS_POL,
                  deNow,
                  deNow ? hCnt_q : {HW{1'b0}},
                  deNow ? vCnt_q : {VW{1'b0}},
                  hCnt_q == '0,
                  (hCnt_q == '0) && (vCnt_q == '0)};
    end
  end

  // First output register, loaded once per pixel tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage0_q <= IDLE_WORD;
    end else if (pix_en) begin
      stage0_q <= stage0_d;
    end
  end

  vga_sig_delay #(
    .WIDTH     (W),
    .DEPTH     (PIPE_DLY),
    .RESET_VAL (IDLE_WORD)
  ) u_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (pix_en),
    .d_i   (stage0_q),
    .q_o   (delayed)
  );

  assign busy = busy_q;
  assign {hsync, vsync, de, x, y, line_start, frame_start} = delayed;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: one full-size instance (line timing) and
// two 8x6 instances with PIPE_DLY = 3 (active-low and active-high syncs).
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  logic clk, rst_n, pix_en, run;
  int   errors, checks;

  logic       aBusy, aHs, aVs, aDe, aLs, aFs;
  logic [9:0] aX, aY;
  logic       sBusy, sHs, sVs, sDe, sLs, sFs;
  logic [2:0] sX, sY;
  logic       pBusy, pHs, pVs, pDe, pLs, pFs;
  logic [2:0] pX, pY;
  logic [10:0] sVec, pVec;

  assign sVec = {sHs, sVs, sDe, sX, sY, sLs, sFs};
  assign pVec = {pHs, pVs, pDe, pX, pY, pLs, pFs};

  vga_timing_gen #(
    .H_ACTIVE(int'(VGA_640X480.hActive)), .H_FP(int'(VGA_640X480.hFp)),
    .H_SYNC(int'(VGA_640X480.hSync)), .H_BP(int'(VGA_640X480.hBp)),
    .V_ACTIVE(int'(VGA_640X480.vActive)), .V_FP(int'(VGA_640X480.vFp)),
    .V_SYNC(int'(VGA_640X480.vSync)), .V_BP(int'(VGA_640X480.vBp)),
    .HS_POL(VGA_640X480.hsPol), .VS_POL(VGA_640X480.vsPol), .PIPE_DLY(0)
  ) dutA (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .run(run), .busy(aBusy),
    .hsync(aHs), .vsync(aVs), .de(aDe), .x(aX), .y(aY),
    .line_start(aLs), .frame_start(aFs)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(2),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .PIPE_DLY(3)
  ) dutS (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .run(run), .busy(sBusy),
    .hsync(sHs), .vsync(sVs), .de(sDe), .x(sX), .y(sY),
    .line_start(sLs), .frame_start(sFs)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(2),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .PIPE_DLY(3)
  ) dutP (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .run(run), .busy(pBusy),
    .hsync(pHs), .vsync(pVs), .de(pDe), .x(pX), .y(pY),
    .line_start(pLs), .frame_start(pFs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected 8x6 output word for raster pixel index p (counted from frame start)
  function automatic logic [10:0] smallExp(input int p, input bit pol);
    int h, v;
    logic deE;
    logic [2:0] xe, ye;
    h   = p % 8;
    v   = (p / 8) % 6;
    deE = (h < 4) && (v < 3);
    xe  = deE ? 3'(h) : 3'd0;
    ye  = deE ? 3'(v) : 3'd0;
    return {(h == 5) ? pol : ~pol, (v == 4) ? pol : ~pol, deE, xe, ye,
            (h == 0), (h == 0) && (v == 0)};
  endfunction

  function automatic logic [10:0] idleVec(input bit pol);
    return {~pol, ~pol, 9'd0};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset;
    rst_n  = 1'b0;
    run    = 1'b0;
    pix_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    pix_en = 1'b1;
    run    = 1'b1;
    rst_n  = 1'b0;
    tick();
    checks++;
    if (sBusy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b exp=0", sBusy); end
    checks++;
    if (sVec !== idleVec(1'b0)) begin errors++; $display("[TB] FAIL reset_small got=%b exp=%b", sVec, idleVec(1'b0)); end
    checks++;
    if (pVec !== idleVec(1'b1)) begin errors++; $display("[TB] FAIL reset_pol got=%b exp=%b", pVec, idleVec(1'b1)); end
    checks++;
    if ({aHs, aVs, aDe, aX, aY, aLs, aFs, aBusy} !== {1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 3'b000})
      begin errors++; $display("[TB] FAIL reset_default hs=%b vs=%b de=%b x=%0d fs=%b busy=%b", aHs, aVs, aDe, aX, aFs, aBusy); end
    run   = 1'b0;
    rst_n = 1'b1;
    repeat (3) tick();
    checks++;
    if (sBusy !== 1'b0 || sVec !== idleVec(1'b0))
      begin errors++; $display("[TB] FAIL idle_hold busy=%b vec=%b exp busy=0 vec=%b", sBusy, sVec, idleVec(1'b0)); end
  endtask

  task automatic test_default_line;
    int hsLow1, hsLow2, deHigh, firstHs, vsLow, lsCnt, fsCnt;
    logic fsFirst;
    logic [9:0] x639;
    hsLow1 = 0; hsLow2 = 0; deHigh = 0; firstHs = 0; vsLow = 0; lsCnt = 0; fsCnt = 0;
    fsFirst = 1'b0; x639 = '0;
    doReset();
    run = 1'b1;
    for (int k = 1; k <= 1600; k++) begin
      tick();
      if (k <= 800 && aHs === 1'b0) hsLow1++;
      if (k > 800 && aHs === 1'b0) hsLow2++;
      if (k <= 800 && aDe === 1'b1) deHigh++;
      if (aHs === 1'b0 && firstHs == 0) firstHs = k;
      if (aVs !== 1'b1) vsLow++;
      if (aLs === 1'b1) lsCnt++;
      if (aFs === 1'b1) fsCnt++;
      if (k == 1) fsFirst = aFs;
      if (k == 640) x639 = aX;
    end
    checks++;
    if (hsLow1 != 96) begin errors++; $display("[TB] FAIL hsync_width_line0 got=%0d exp=96", hsLow1); end
    checks++;
    if (hsLow2 != 96) begin errors++; $display("[TB] FAIL hsync_width_line1 got=%0d exp=96", hsLow2); end
    checks++;
    if (firstHs != 657) begin errors++; $display("[TB] FAIL hsync_start got=%0d exp=657", firstHs); end
    checks++;
    if (deHigh != 640) begin errors++; $display("[TB] FAIL de_width got=%0d exp=640", deHigh); end
    checks++;
    if (vsLow != 0) begin errors++; $display("[TB] FAIL vsync_idle got=%0d exp=0", vsLow); end
    checks++;
    if (lsCnt != 2) begin errors++; $display("[TB] FAIL line_start_count got=%0d exp=2", lsCnt); end
    checks++;
    if (fsCnt != 1 || fsFirst !== 1'b1) begin errors++; $display("[TB] FAIL frame_start_default count=%0d first=%b exp 1/1", fsCnt, fsFirst); end
    checks++;
    if (x639 !== 10'd639) begin errors++; $display("[TB] FAIL x_last got=%0d exp=639", x639); end
    checks++;
    if (aBusy !== 1'b1) begin errors++; $display("[TB] FAIL default_busy got=%b exp=1", aBusy); end
  endtask

  task automatic test_small_frame;
    logic [10:0] exp;
    doReset();
    run = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      tick();
      exp = (k < 4) ? idleVec(1'b0) : smallExp(k - 4, 1'b0);
      checks++;
      if (sVec !== exp || sBusy !== 1'b1)
        begin errors++; $display("[TB] FAIL small_frame tick=%0d got=%b busy=%b exp=%b busy=1", k, sVec, sBusy, exp); end
    end
  endtask

  task automatic test_pix_en_slow;
    logic [10:0] exp, prev;
    int k;
    k = 0;
    doReset();
    run  = 1'b1;
    prev = sVec;
    for (int c = 0; c < 4 * 56; c++) begin
      pix_en = (c % 4 == 0);
      tick();
      if (pix_en) k++;
      exp = (k < 4) ? idleVec(1'b0) : smallExp(k - 4, 1'b0);
      checks++;
      if (sVec !== exp)
        begin errors++; $display("[TB] FAIL slow_value clk=%0d tick=%0d got=%b exp=%b", c, k, sVec, exp); end
      if (!pix_en) begin
        checks++;
        if (sVec !== prev)
          begin errors++; $display("[TB] FAIL slow_stable clk=%0d got=%b exp=%b", c, sVec, prev); end
      end
      prev = sVec;
    end
    pix_en = 1'b1;
  endtask

  task automatic test_stop;
    logic [10:0] exp;
    logic expBusy;
    doReset();
    for (int k = 1; k <= 110; k++) begin
      run = (k <= 10);
      tick();
      expBusy = (k < 48);
      exp = (k < 4 || k - 4 > 47) ? idleVec(1'b0) : smallExp(k - 4, 1'b0);
      checks++;
      if (sVec !== exp || sBusy !== expBusy)
        begin errors++; $display("[TB] FAIL stop tick=%0d got=%b busy=%b exp=%b busy=%b", k, sVec, sBusy, exp, expBusy); end
    end
  endtask

  task automatic test_resume;
    logic [10:0] exp;
    int fs1, fs2;
    fs1 = 0; fs2 = 0;
    doReset();
    for (int k = 1; k <= 70; k++) begin
      run = (k <= 10) || (k >= 30);
      tick();
      if (sFs === 1'b1) begin
        if (fs1 == 0) fs1 = k;
        else if (fs2 == 0) fs2 = k;
      end
      exp = (k < 4) ? idleVec(1'b0) : smallExp(k - 4, 1'b0);
      checks++;
      if (sVec !== exp || sBusy !== 1'b1)
        begin errors++; $display("[TB] FAIL resume tick=%0d got=%b busy=%b exp=%b busy=1", k, sVec, sBusy, exp); end
    end
    checks++;
    if (fs2 - fs1 != 48 || fs1 != 4)
      begin errors++; $display("[TB] FAIL resume_period first=%0d second=%0d exp 4/52", fs1, fs2); end
  endtask

  task automatic test_async_reset;
    logic [10:0] exp;
    bit found;
    found = 1'b0;
    doReset();
    run = 1'b1;
    for (int k = 1; k <= 40 && !found; k++) begin
      tick();
      if (sHs === 1'b0) found = 1'b1;
    end
    checks++;
    if (!found) begin errors++; $display("[TB] FAIL wait_hsync got=timeout exp=hsync low within 40 ticks"); end
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({sHs, sVs, sDe, sLs, sFs, sBusy} !== 6'b110000)
      begin errors++; $display("[TB] FAIL async_reset got hs/vs/de/ls/fs/busy=%b exp=110000", {sHs, sVs, sDe, sLs, sFs, sBusy}); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp = (k < 4) ? idleVec(1'b0) : smallExp(k - 4, 1'b0);
      checks++;
      if (sVec !== exp)
        begin errors++; $display("[TB] FAIL post_reset tick=%0d got=%b exp=%b", k, sVec, exp); end
    end
  endtask

  task automatic test_polarity;
    logic [10:0] exp;
    doReset();
    run = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      tick();
      exp = (k < 4) ? idleVec(1'b1) : smallExp(k - 4, 1'b1);
      checks++;
      if (pVec !== exp)
        begin errors++; $display("[TB] FAIL polarity tick=%0d got=%b exp=%b", k, pVec, exp); end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    run    = 1'b0;
    pix_en = 1'b1;
    test_reset();
    test_default_line();
    test_small_frame();
    test_pix_en_slow();
    test_stop();
    test_resume();
    test_async_reset();
    test_polarity();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog got=timeout exp=bench completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
